// File: rtl/tr_adc_avg_if.sv
// Sample/result bundle between the ADC front end, tr_adc_avg and TR.
// Carries glitch_cnt only when TR_ADC_GLITCH_REJECT_EN is defined.
interface tr_adc_avg_if #(
    parameter int DW = 36
);
    logic          data_valid;
    logic [DW-1:0] adc_data;
    logic          flush;
    logic [DW-1:0] x;
    logic          x_valid;
    logic          filled;
`ifdef TR_ADC_GLITCH_REJECT_EN
    logic [15:0]   glitch_cnt;

    modport master (
        output data_valid, adc_data, flush,
        input  x, x_valid, filled, glitch_cnt
    );
    modport slave (
        input  data_valid, adc_data, flush,
        output x, x_valid, filled, glitch_cnt
    );
`else
    modport master (
        output data_valid, adc_data, flush,
        input  x, x_valid, filled
    );
    modport slave (
        input  data_valid, adc_data, flush,
        output x, x_valid, filled
    );
`endif
endinterface

// File: rtl/tr_adc_avg.sv
// Boxcar moving average (2^LOG2_WIN taps) ahead of the TR tracking block.
// Optional glitch rejection in RUN: define TR_ADC_GLITCH_REJECT_EN.
module tr_adc_avg #(
    parameter int DW        = 36,
    parameter int LOG2_WIN  = 3,
    parameter int GLITCH_TH = 1000
) (
    input  logic        clk,
    input  logic        rst,
    tr_adc_avg_if.slave bus
);
    localparam int WIN = 1 << LOG2_WIN;
    localparam int SW  = DW + LOG2_WIN;

    typedef enum logic {FILL, RUN} state_t;

    state_t                state_q;
    logic [SW-1:0]         sum_q;
    logic [LOG2_WIN-1:0]   wr_ptr_q;
    logic [LOG2_WIN-1:0]   fill_cnt_q;
    logic [DW-1:0]         x_q;
    logic                  x_valid_q;
    logic [DW-1:0]         buf_q [WIN];

    logic                  take;
    logic [DW-1:0]         samp_d;
    logic [DW-1:0]         old_d;
    logic [SW-1:0]         sum_d;
    logic [DW-1:0]         x_d;
    logic                  last_fill;

    assign take      = bus.data_valid && !bus.flush;
    assign last_fill = (fill_cnt_q == LOG2_WIN'(WIN - 1));

`ifdef TR_ADC_GLITCH_REJECT_EN
    logic [15:0]   glitch_cnt_q;
    logic [DW-1:0] diff;
    logic          glitch;

    always_comb begin
        diff   = (bus.adc_data > x_q) ? bus.adc_data - x_q
                                      : x_q - bus.adc_data;
        glitch = (state_q == RUN) && (diff > DW'(GLITCH_TH));
        samp_d = glitch ? x_q : bus.adc_data;
    end

    assign bus.glitch_cnt = glitch_cnt_q;
`else
    assign samp_d = bus.adc_data;
`endif

    // Stale RAM entries only count once the window has wrapped
    assign old_d = (state_q == RUN) ? buf_q[wr_ptr_q] : '0;
    assign sum_d = sum_q + SW'(samp_d) - SW'(old_d);
    assign x_d   = sum_d[SW-1:LOG2_WIN];

    always_ff @(posedge clk) begin
        if (!rst && take) begin
            buf_q[wr_ptr_q] <= samp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            x_q        <= '0;
            x_valid_q  <= 1'b0;
`ifdef TR_ADC_GLITCH_REJECT_EN
            glitch_cnt_q <= '0;
`endif
        end else if (bus.flush) begin
            state_q    <= FILL;
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            x_valid_q  <= 1'b0;
`ifdef TR_ADC_GLITCH_REJECT_EN
            glitch_cnt_q <= '0;
`endif
        end else begin
            x_valid_q <= 1'b0;
            if (take) begin
                sum_q    <= sum_d;
                wr_ptr_q <= wr_ptr_q + 1'b1;
                unique case (state_q)
                    FILL: begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        if (last_fill) begin
                            state_q   <= RUN;
                            x_q       <= x_d;
                            x_valid_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        x_q       <= x_d;
                        x_valid_q <= 1'b1;
`ifdef TR_ADC_GLITCH_REJECT_EN
                        if (glitch && glitch_cnt_q != 16'hFFFF) begin
                            glitch_cnt_q <= glitch_cnt_q + 16'd1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.x       = x_q;
    assign bus.x_valid = x_valid_q;
    assign bus.filled  = (state_q == RUN);
endmodule
